// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, key-schedule constants and the
// GF(2^8) xtime helper. The round datapath's MixColumns also uses this helper.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;
  localparam logic [3:0] NR         = 4'd10;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward substitution box, purely combinational 256-entry lookup.
// Row 0 of the table occupies the most significant bits, so entry a sits at byte 255-a.
module sbox (
  input  logic [7:0] endereco,
  output logic [7:0] dado
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~endereco, 3'b000};
  assign dado      = SBOX_TABLE[w_bit_idx +: 8];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key every 5 cycles (4 SubWord
// cycles through a single shared sbox, then one word-mixing cycle).
module key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] chave,
  output logic [127:0] chave_rodada,
  output logic [3:0]   rodada,
  output logic         chave_valida,
  output logic         ocupado,
  output logic         fim
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_w0, r_w1, r_w2, r_w3;
  logic [31:0]  r_t;
  logic [1:0]   r_cnt;
  logic [7:0]   r_rcon;
  logic [127:0] r_chave_rodada;
  logic [3:0]   r_rodada;
  logic         r_valida;
  logic         r_fim;

  logic [1:0]   w_sel;
  logic [4:0]   w_byte_lsb;
  logic [31:0]  w_rot;
  logic [7:0]   w_sbox_addr;
  logic [7:0]   w_sbox_dado;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [3:0]   w_rodada_inc;

  // Bytes of RotWord(w3) are substituted MSB first: counter 0 handles byte 3
  assign w_sel       = 2'd3 - r_cnt;
  assign w_byte_lsb  = {w_sel, 3'b000};
  assign w_rot       = {r_w3[23:0], r_w3[31:24]};
  assign w_sbox_addr = w_rot[w_byte_lsb +: 8];

  sbox u_sbox (
    .endereco (w_sbox_addr),
    .dado     (w_sbox_dado)
  );

  assign w_n0         = r_w0 ^ r_t ^ {r_rcon, 24'h000000};
  assign w_n1         = r_w1 ^ w_n0;
  assign w_n2         = r_w2 ^ w_n1;
  assign w_n3         = r_w3 ^ w_n2;
  assign w_rodada_inc = r_rodada + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SUB;
        else       w_state_nxt = ST_IDLE;
      end
      ST_SUB: begin
        if (r_cnt == 2'd3) w_state_nxt = ST_MIX;
        else               w_state_nxt = ST_SUB;
      end
      ST_MIX: begin
        if (w_rodada_inc == NR) w_state_nxt = ST_DONE;
        else                    w_state_nxt = ST_SUB;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Valid/fim default low every cycle so each is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w0           <= 32'h0;
      r_w1           <= 32'h0;
      r_w2           <= 32'h0;
      r_w3           <= 32'h0;
      r_t            <= 32'h0;
      r_cnt          <= 2'd0;
      r_rcon         <= 8'h00;
      r_chave_rodada <= 128'h0;
      r_rodada       <= 4'd0;
      r_valida       <= 1'b0;
      r_fim          <= 1'b0;
    end else begin
      r_valida <= 1'b0;
      r_fim    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_w0           <= chave[127:96];
            r_w1           <= chave[95:64];
            r_w2           <= chave[63:32];
            r_w3           <= chave[31:0];
            r_chave_rodada <= chave;
            r_rodada       <= 4'd0;
            r_valida       <= 1'b1;
            r_rcon         <= RCON_INIT;
            r_cnt          <= 2'd0;
          end
        end
        ST_SUB: begin
          r_t[w_byte_lsb +: 8] <= w_sbox_dado;
          r_cnt                <= r_cnt + 2'd1;
        end
        ST_MIX: begin
          r_w0           <= w_n0;
          r_w1           <= w_n1;
          r_w2           <= w_n2;
          r_w3           <= w_n3;
          r_chave_rodada <= {w_n0, w_n1, w_n2, w_n3};
          r_rodada       <= w_rodada_inc;
          r_valida       <= 1'b1;
          r_rcon         <= xtime(r_rcon);
          r_cnt          <= 2'd0;
          r_fim          <= (w_rodada_inc == NR);
        end
        default: begin
        end
      endcase
    end
  end

  assign chave_rodada = r_chave_rodada;
  assign rodada       = r_rodada;
  assign chave_valida = r_valida;
  assign fim          = r_fim;
  assign ocupado      = (r_state != ST_IDLE);

endmodule
